// File: rtl/alu_issue_ctrl.sv
// Issue controller sharing one 32-bit ALU between two requesters: round-robin grant,
// operand hold for the opcode latency, and result return over a valid/ready channel.
module alu_issue_ctrl #(
    parameter int INT_LAT = 1,
    parameter int FP_LAT  = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [4:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [4:0]  req1_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_op,
    input  logic [63:0] alu_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [63:0] rsp_data,
    output logic        rsp_err
);

    localparam int MAX_LAT = (INT_LAT > FP_LAT) ? INT_LAT : FP_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state;
    state_t          state_next;
    logic            rr_ptr;
    logic [CW-1:0]   cnt;
    logic            err_pend;

    logic            grant_id;
    logic            accept;
    logic [31:0]     sel_a;
    logic [31:0]     sel_b;
    logic [4:0]      sel_op;
    logic            sel_illegal;
    logic [CW-1:0]   sel_lat;

    // A lone valid requester wins regardless of rr_ptr; rr_ptr only breaks ties.
    always_comb begin
        grant_id = (req0_valid & req1_valid) ? rr_ptr : req1_valid;
        accept   = (state == IDLE) & (req0_valid | req1_valid);
        sel_a    = grant_id ? req1_a  : req0_a;
        sel_b    = grant_id ? req1_b  : req0_b;
        sel_op   = grant_id ? req1_op : req0_op;
        sel_illegal = sel_op[4];
        if (sel_illegal) begin
            sel_lat = CW'(1);
        end else if (sel_op == 5'd5 || sel_op == 5'd6 || sel_op == 5'd7) begin
            sel_lat = CW'(FP_LAT);
        end else begin
            sel_lat = CW'(INT_LAT);
        end
    end

    assign req0_ready = rst_n & accept & ~grant_id;
    assign req1_ready = rst_n & accept &  grant_id;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = EXEC;
            EXEC: if (cnt == CW'(1)) state_next = RESP;
            RESP: if (rsp_valid & rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            cnt       <= '0;
            err_pend  <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        rr_ptr   <= ~grant_id;
                        rsp_id   <= grant_id;
                        cnt      <= sel_lat;
                        err_pend <= sel_illegal;
                        // Illegal ops leave the ALU inputs untouched.
                        if (!sel_illegal) begin
                            alu_a  <= sel_a;
                            alu_b  <= (sel_op == 5'd6) ? {~sel_b[31], sel_b[30:0]} : sel_b;
                            alu_op <= sel_op;
                        end
                    end
                end
                EXEC: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= err_pend;
                        rsp_data  <= err_pend ? 64'd0 : alu_out;
                    end
                end
                RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
